// File: rtl/timed_mem_pkg.sv
// ============================================================================
// timed_mem_pkg : shared FSM state type and default parameters for the
//                 timed block memory.  Revision 1.0
// ============================================================================
`default_nettype none

package timed_mem_pkg;

  localparam int DEF_ADDR_W      = 15;
  localparam int DEF_DATA_W      = 32;
  localparam int DEF_BLOCK_WORDS = 4;
  localparam int DEF_LATENCY     = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/mem_latency_timer.sv
// ============================================================================
// mem_latency_timer : loadable down-counter; o_done flags a count of zero.
//                     Revision 1.0
// ============================================================================
`default_nettype none

module mem_latency_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_count,
  output logic             o_done
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_count && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_done = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/timed_block_memory.sv
// ============================================================================
// timed_block_memory : word memory answering each request with the word and
//                      its aligned block after a fixed latency. Revision 1.0
// ============================================================================
`default_nettype none

module timed_block_memory
  import timed_mem_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int BLOCK_WORDS = DEF_BLOCK_WORDS,
  parameter int LATENCY     = DEF_LATENCY
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_write,
  input  logic [ADDR_W-1:0]             req_addr,
  input  logic [DATA_W-1:0]             wr_data,
  output logic                          resp_valid,
  output logic [DATA_W-1:0]             resp_data,
  output logic [DATA_W*BLOCK_WORDS-1:0] resp_block,
  output logic                          busy
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_W = $clog2(LATENCY + 1);
  // WAIT spans LATENCY-1 cycles; the final one is the done cycle itself.
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'((LATENCY >= 2) ? (LATENCY - 2) : 0);

  state_t r_state;
  state_t w_next;

  logic                          r_write;
  logic [ADDR_W-1:0]             r_addr;
  logic [DATA_W-1:0]             r_wdata;
  logic [DATA_W-1:0]             r_resp_data;
  logic [DATA_W*BLOCK_WORDS-1:0] r_resp_block;

  // Unwritten words read back as their own address; r_written marks overrides.
  logic [DATA_W-1:0]             r_mem [DEPTH];
  logic [DEPTH-1:0]              r_written = '0;

  logic                          w_accept;
  logic                          w_count;
  logic                          w_done;
  logic                          w_enter_resp;
  logic                          w_wr;
  logic [ADDR_W-1:0]             w_addr;
  logic [ADDR_W-1:0]             w_base;
  logic [DATA_W-1:0]             w_wdata;
  logic [DATA_W-1:0]             w_word;
  logic [DATA_W*BLOCK_WORDS-1:0] w_block;

  always_comb begin
    w_next       = r_state;
    w_accept     = 1'b0;
    w_count      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          w_accept = 1'b1;
          w_next   = (LATENCY == 1) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        w_count = 1'b1;
        if (w_done) begin
          w_next = ST_RESP;
        end
      end
      ST_RESP: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
    w_enter_resp = (w_next == ST_RESP) && (r_state != ST_RESP);
  end

  mem_latency_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_accept),
    .i_load_val (LOAD_VAL),
    .i_count    (w_count),
    .o_done     (w_done)
  );

  // With LATENCY=1 the response is formed on the accept edge, before latching.
  assign w_addr  = (r_state == ST_IDLE) ? req_addr  : r_addr;
  assign w_wr    = (r_state == ST_IDLE) ? req_write : r_write;
  assign w_wdata = (r_state == ST_IDLE) ? wr_data   : r_wdata;
  assign w_base  = w_addr & ~ADDR_W'(BLOCK_WORDS - 1);
  assign w_word  = w_wr ? w_wdata
                 : (r_written[w_addr] ? r_mem[w_addr] : DATA_W'(w_addr));

  generate
    for (genvar gi = 0; gi < BLOCK_WORDS; gi++) begin : g_block
      logic [ADDR_W-1:0] w_idx;
      assign w_idx = w_base + ADDR_W'(gi);
      assign w_block[gi*DATA_W +: DATA_W] =
          (w_wr && (w_idx == w_addr)) ? w_wdata
          : (r_written[w_idx] ? r_mem[w_idx] : DATA_W'(w_idx));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_write      <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_resp_data  <= '0;
      r_resp_block <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_write <= req_write;
        r_addr  <= req_addr;
        r_wdata <= wr_data;
      end
      if (w_enter_resp) begin
        r_resp_data  <= w_word;
        r_resp_block <= w_block;
      end
    end
  end

  // Storage survives reset; only the commit itself is suppressed by it.
  always_ff @(posedge clk) begin
    if (rst && w_enter_resp && w_wr) begin
      r_mem[w_addr]     <= w_wdata;
      r_written[w_addr] <= 1'b1;
    end
  end

  assign req_ready  = (r_state == ST_IDLE);
  assign busy       = (r_state == ST_WAIT) || (r_state == ST_RESP);
  assign resp_valid = (r_state == ST_RESP);
  assign resp_data  = r_resp_data;
  assign resp_block = r_resp_block;

endmodule

`default_nettype wire

// File: tb/tb_timed_block_memory.sv
// ============================================================================
// tb_timed_block_memory : directed + random checks of timed_block_memory
//                         against an array reference model. Revision 1.0
// ============================================================================
`default_nettype none

module tb_timed_block_memory;

  localparam int AW  = 15;
  localparam int DW  = 32;
  localparam int BW  = 4;
  localparam int LAT = 8;
  localparam int BLK = DW * BW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic           req_valid, req_ready, req_write, resp_valid, busy;
  logic [AW-1:0]  req_addr;
  logic [DW-1:0]  wr_data, resp_data;
  logic [BLK-1:0] resp_block;

  logic           d1_valid, d1_ready, d1_write, d1_resp_valid, d1_busy;
  logic [AW-1:0]  d1_addr;
  logic [DW-1:0]  d1_wdata, d1_resp_data;
  logic [BLK-1:0] d1_resp_block;

  timed_block_memory #(.ADDR_W(AW), .DATA_W(DW), .BLOCK_WORDS(BW), .LATENCY(LAT)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .wr_data(wr_data),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_block(resp_block), .busy(busy)
  );

  timed_block_memory #(.ADDR_W(AW), .DATA_W(DW), .BLOCK_WORDS(BW), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(d1_valid), .req_ready(d1_ready),
    .req_write(d1_write), .req_addr(d1_addr), .wr_data(d1_wdata),
    .resp_valid(d1_resp_valid), .resp_data(d1_resp_data), .resp_block(d1_resp_block),
    .busy(d1_busy)
  );

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] mdl [2**AW];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [BLK-1:0] obs, input logic [BLK-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [BLK-1:0] mdl_block(input int a);
    logic [BLK-1:0] r;
    int base;
    base = a - (a % BW);
    for (int i = 0; i < BW; i++) r[i*DW +: DW] = mdl[base + i];
    return r;
  endfunction

  // One request on the LATENCY=8 instance; ignored junk writes are thrown at it while busy.
  task automatic txn(input bit wr, input int a, input logic [DW-1:0] d);
    int n;
    chk("ready_before", BLK'(req_ready), BLK'(1));
    req_valid = 1'b1; req_write = wr; req_addr = AW'(a); wr_data = d;
    tick();
    req_valid = 1'b0;
    if (wr) mdl[a] = d;
    n = 0;
    while (!resp_valid && n < 40) begin
      req_valid = ($urandom_range(0, 1) == 1);
      req_write = 1'b1; req_addr = 15'h0100; wr_data = $urandom;
      tick();
      n++;
    end
    req_valid = 1'b0;
    chk("latency", BLK'(n), BLK'(LAT - 1));
    chk("resp_data", BLK'(resp_data), BLK'(mdl[a]));
    chk("resp_block", resp_block, mdl_block(a));
    tick();
    chk("pulse_end", BLK'({resp_valid, busy, req_ready}), BLK'(3'b001));
  endtask

  task automatic txn1(input bit wr, input int a, input logic [DW-1:0] d,
                      input logic [DW-1:0] exp_d, input logic [BLK-1:0] exp_b);
    chk("d1_ready", BLK'(d1_ready), BLK'(1));
    d1_valid = 1'b1; d1_write = wr; d1_addr = AW'(a); d1_wdata = d;
    tick();
    d1_valid = 1'b0;
    chk("d1_resp_valid", BLK'(d1_resp_valid), BLK'(1));
    chk("d1_resp_data", BLK'(d1_resp_data), BLK'(exp_d));
    chk("d1_resp_block", d1_resp_block, exp_b);
    tick();
    chk("d1_pulse_end", BLK'(d1_resp_valid), BLK'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_q[$];
    int resp_n;
    int n;
    int a;
    bit wr;

    for (int i = 0; i < 2**AW; i++) mdl[i] = DW'(i);
    rst = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; wr_data = '0;
    d1_valid = 1'b0; d1_write = 1'b0; d1_addr = '0; d1_wdata = '0;
    tick(); tick();
    chk("rst_outputs", BLK'({resp_valid, busy}), BLK'(0));
    chk("rst_data", BLK'(resp_data), BLK'(0));
    chk("rst_block", resp_block, '0);
    rst = 1'b1;
    tick();
    chk("rst_ready", BLK'(req_ready), BLK'(1));

    // Directed reads/writes, including the top-of-memory block.
    txn(1'b0, 'h0005, '0);
    chk("hold_block_5", resp_block, {32'h7, 32'h6, 32'h5, 32'h4});
    txn(1'b1, 'h0010, 32'hDEADBEEF);
    txn(1'b0, 'h0012, '0);
    chk("rd12_slice0", BLK'(resp_block[DW-1:0]), BLK'(32'hDEADBEEF));
    chk("rd12_data", BLK'(resp_data), BLK'(32'h12));
    txn(1'b0, 'h7FFF, '0);
    chk("hold_block_top", resp_block, {32'h7FFF, 32'h7FFE, 32'h7FFD, 32'h7FFC});

    // Back-to-back pressure: valid held high for 27 cycles.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 15'h0009;
    resp_n = 0;
    for (int c = 0; c < 27; c++) begin
      if (req_ready) acc_q.push_back(c);
      if (resp_valid) begin
        resp_n++;
        chk("stream_data", BLK'(resp_data), BLK'(mdl[9]));
      end
      tick();
    end
    req_valid = 1'b0;
    chk("stream_accepts", BLK'(acc_q.size()), BLK'(3));
    for (int i = 0; i < acc_q.size(); i++) chk("stream_accept_cycle", BLK'(acc_q[i]), BLK'(9 * i));
    chk("stream_resps", BLK'(resp_n), BLK'(3));
    n = 0;
    while (busy && n < 20) begin tick(); n++; end
    chk("stream_drain", BLK'(busy), BLK'(0));

    // Reset in the middle of a write aborts it.
    req_valid = 1'b1; req_write = 1'b1; req_addr = 15'h0020; wr_data = 32'h1234;
    tick();
    req_valid = 1'b0;
    tick(); tick(); tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    resp_n = 0;
    for (int c = 0; c < 12; c++) begin
      if (resp_valid) resp_n++;
      tick();
    end
    chk("abort_no_resp", BLK'(resp_n), BLK'(0));
    chk("abort_data", BLK'(resp_data), BLK'(0));
    chk("abort_block", resp_block, '0);
    chk("abort_state", BLK'({busy, req_ready}), BLK'(2'b01));
    txn(1'b0, 'h0020, '0);
    chk("abort_readback", BLK'(resp_data), BLK'(32'h20));

    // Reset wins over a simultaneous request.
    rst = 1'b0; req_valid = 1'b1; req_write = 1'b1; req_addr = 15'h0030; wr_data = 32'hFF;
    tick();
    rst = 1'b1; req_valid = 1'b0;
    chk("prio_busy", BLK'(busy), BLK'(0));
    tick();
    chk("prio_busy2", BLK'(busy), BLK'(0));
    txn(1'b0, 'h0030, '0);

    // Random traffic, biased toward a few hot blocks so reads see prior writes.
    for (int k = 0; k < 24; k++) begin
      wr = ($urandom_range(0, 1) == 1);
      case ($urandom_range(0, 2))
        0:       a = $urandom_range(0, 2**AW - 1);
        1:       a = $urandom_range(2**AW - 8, 2**AW - 1);
        default: a = $urandom_range(16'h0040, 16'h004F);
      endcase
      txn(wr, a, $urandom);
    end
    txn(1'b0, 'h0100, '0);

    // LATENCY=1 instance.
    txn1(1'b0, 'h0003, '0, 32'h3, {32'h3, 32'h2, 32'h1, 32'h0});
    txn1(1'b1, 'h0008, 32'hCAFE, 32'hCAFE, {32'hB, 32'hA, 32'h9, 32'hCAFE});
    txn1(1'b0, 'h0009, '0, 32'h9, {32'hB, 32'hA, 32'h9, 32'hCAFE});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
